fpu_job_sequencer: RTL and testbench
====================================

// Module: fpu_job_sequencer
// PURPOSE
//  Initiator side of the FPU start/done handshake. Walks a job of N operand pairs in BRAM.
//  For each pair it reads a and b, issues one op to the FPU wrapper, and waits for done.
//  It then writes the result back to BRAM. Sits between the host job interface and the FPU.
// PARAMETERS
//  BRAM_WIDTH      10  BRAM address width (words); also width of job_count
//  DATA_WIDTH      32  operand/result width
//  TIMEOUT_CYCLES  64  max WAIT cycles for fpu_done before abort (must be > 31)
// PORTS
//  clock         in   1           system clock, rising edge
//  reset_n       in   1           asynchronous, active-low reset
//  job_start     in   1           1-cycle request; sampled only in IDLE
//  job_op        in   3           FPU op for whole job; 3'b000 illegal
//  job_base      in   BRAM_WIDTH  addr of first operand pair
//  job_res_base  in   BRAM_WIDTH  addr of first result word
//  job_count     in   BRAM_WIDTH  number of pairs N
//  busy          out  1           high in every state except IDLE
//  job_done      out  1           1-cycle pulse at job end (normal or error)
//  job_error     out  1           sticky; cleared when next job_start is accepted
//  mem_rd_en     out  1           BRAM read enable; rdata valid next cycle
//  mem_raddr     out  BRAM_WIDTH  BRAM read address
//  mem_rdata     in   DATA_WIDTH  BRAM read data (1-cycle latency)
//  mem_wr_en     out  1           BRAM write enable
//  mem_waddr     out  BRAM_WIDTH  BRAM write address
//  mem_wdata     out  DATA_WIDTH  BRAM write data
//  fpu_start     out  1           1-cycle issue pulse to FPU
//  fpu_op        out  3           registered; held for whole job
//  fpu_a, fpu_b  out  DATA_WIDTH  registered; held stable from ISSUE until fpu_done
//  fpu_result    in   DATA_WIDTH  FPU result, valid while fpu_done=1
//  fpu_done      in   1           FPU completion, single cycle
// BEHAVIOUR
//  Reset: state=IDLE, idx=0; all outputs 0 (incl. fpu_op/a/b, job_error). Reset mid-job
//   abandons the job immediately; no further mem/FPU activity, no job_done pulse.
//  Job start (IDLE & job_start):
//   - latch op/base/res_base/count; clear job_error.
//   - job_op==0: set job_error; go to DONE.
//   - N==0: go to DONE.
//   - otherwise go to RD_A with idx=0.
//   - job_start in any other state: ignored.
//  States per pair i (addresses mod 2^BRAM_WIDTH, wrap silently):
//   RD_A   : mem_rd_en=1, mem_raddr=base+2i                                  -> RD_B
//   RD_B   : mem_rd_en=1, mem_raddr=base+2i+1; fpu_a<=mem_rdata              -> LOAD_B
//   LOAD_B : fpu_b<=mem_rdata                                                -> ISSUE
//   ISSUE  : fpu_start=1; clear watchdog                                     -> WAIT
//   WAIT   : fpu_done=1: res<=fpu_result                                     -> WRITE
//            else watchdog+1; at TIMEOUT_CYCLES: job_error=1                  -> DONE
//   WRITE  : mem_wr_en=1, mem_waddr=res_base+i, mem_wdata=res
//            i==N-1: -> DONE; else idx++                                      -> RD_A
//   DONE   : job_done=1 for one cycle                                        -> IDLE
//  Timing: fpu_done before ISSUE's next edge is ignored. Per pair: 4 + FPU latency + 1 cycles.
//   With the 31-cycle FPU this is 36 cycles/pair; job_done in cycle 36*N after first RD_A.
//  Never asserts fpu_start outside ISSUE, so at most one op is in flight.
//  mem_rd_en and mem_wr_en are never high in the same cycle.
//  Timeout abort: results already written remain; remaining pairs are skipped.
// TESTING
//  1. N=1, op=1, base=0x010: mem[0x010]=3, mem[0x011]=5; FPU model returns a+b after 31
//     cycles -> mem[res_base]=8, job_done exactly 36 cycles after first RD_A, busy low after.
//  2. N=4, res_base=0x200 -> 4 writes at 0x200..0x203 in order, one fpu_start per pair,
//     fpu_a/fpu_b stable through each WAIT, job_done at cycle 144.
//  3. job_count=0 -> no mem/FPU activity; job_done one cycle after the start edge;
//     job_error=0. job_op=0 -> same, but job_error=1.
//  4. FPU model never raises done, TIMEOUT=64 -> job_error=1 after 64 WAIT cycles;
//     job_done pulses; no write for that pair.
//  5. base=0x3FE, N=2 (BRAM_WIDTH=10) -> reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap);
//     second job_start pulse mid-job is ignored.
//  6. reset_n low during WAIT of pair 2 -> all outputs 0 asynchronously; after release,
//     IDLE, no job_done; new job runs cleanly.

Source files
------------

// File: rtl/fpu_job_sequencer_if.sv
// Bundle of the host job, BRAM and FPU signals seen by the job sequencer.
// The master view belongs to the sequencer. The slave view belongs to whatever
// drives the host side and models the BRAM and FPU.
interface fpu_job_sequencer_if #(
    parameter int BRAM_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // Host job interface
    logic                  job_start;
    logic [2:0]            job_op;
    logic [BRAM_WIDTH-1:0] job_base;
    logic [BRAM_WIDTH-1:0] job_res_base;
    logic [BRAM_WIDTH-1:0] job_count;
    logic                  busy;
    logic                  job_done;
    logic                  job_error;

    // BRAM port (read data arrives one cycle after mem_rd_en)
    logic                  mem_rd_en;
    logic [BRAM_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_wr_en;
    logic [BRAM_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // FPU start/done handshake
    logic                  fpu_start;
    logic [2:0]            fpu_op;
    logic [DATA_WIDTH-1:0] fpu_a;
    logic [DATA_WIDTH-1:0] fpu_b;
    logic [DATA_WIDTH-1:0] fpu_result;
    logic                  fpu_done;

    modport master (
        input  job_start, job_op, job_base, job_res_base, job_count,
        output busy, job_done, job_error,
        output mem_rd_en, mem_raddr, mem_wr_en, mem_waddr, mem_wdata,
        input  mem_rdata,
        output fpu_start, fpu_op, fpu_a, fpu_b,
        input  fpu_result, fpu_done
    );

    modport slave (
        output job_start, job_op, job_base, job_res_base, job_count,
        input  busy, job_done, job_error,
        input  mem_rd_en, mem_raddr, mem_wr_en, mem_waddr, mem_wdata,
        output mem_rdata,
        input  fpu_start, fpu_op, fpu_a, fpu_b,
        output fpu_result, fpu_done
    );
endinterface

// File: rtl/fpu_job_sequencer.sv
// FPU job sequencer: walks N operand pairs in BRAM. For each pair it fetches a and b,
// issues one FPU op, waits for done (with a watchdog) and writes the result back.
// Only one op is ever in flight. Read and write enables are never high together,
// because each is decoded from its own state.
module fpu_job_sequencer #(
    parameter int BRAM_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    fpu_job_sequencer_if.master bus
);

    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT cycle index before the watchdog gives up (WAIT lasts TIMEOUT_CYCLES cycles)
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_LOAD_B,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q,    state_d;
    logic [BRAM_WIDTH-1:0] idx_q,      idx_d;
    logic [BRAM_WIDTH-1:0] base_q,     base_d;
    logic [BRAM_WIDTH-1:0] res_base_q, res_base_d;
    logic [BRAM_WIDTH-1:0] count_q,    count_d;
    logic [2:0]            op_q,       op_d;
    logic [DATA_WIDTH-1:0] a_q,        a_d;
    logic [DATA_WIDTH-1:0] b_q,        b_d;
    logic [DATA_WIDTH-1:0] res_q,      res_d;
    logic [WD_WIDTH-1:0]   wd_q,       wd_d;
    logic                  error_q,    error_d;

    // Address of operand a for the current pair; wraps modulo the BRAM size
    logic [BRAM_WIDTH-1:0] pair_addr;
    logic [BRAM_WIDTH-1:0] last_idx;

    assign pair_addr = base_q + (idx_q << 1);
    assign last_idx  = count_q - BRAM_WIDTH'(1);

    // State and datapath registers; an asynchronous reset abandons any job in progress
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            res_base_q <= '0;
            count_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            wd_q       <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            res_base_q <= res_base_d;
            count_q    <= count_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            wd_q       <= wd_d;
            error_q    <= error_d;
        end
    end

    // Next-state and datapath update for the per-pair walk
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        base_d     = base_q;
        res_base_d = res_base_q;
        count_d    = count_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        wd_d       = wd_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.job_start) begin
                    op_d       = bus.job_op;
                    base_d     = bus.job_base;
                    res_base_d = bus.job_res_base;
                    count_d    = bus.job_count;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    if (bus.job_op == 3'b000) begin
                        // Illegal op: report it and finish without touching BRAM or FPU
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.job_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                state_d = S_RD_B;
            end
            S_RD_B: begin
                // Data for the read issued in RD_A is on mem_rdata now
                a_d     = bus.mem_rdata;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_d     = bus.mem_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // fpu_done is only honoured here; earlier pulses are ignored
                if (bus.fpu_done) begin
                    res_d   = bus.fpu_result;
                    state_d = S_WRITE;
                end else if (wd_q == WD_LAST) begin
                    // Watchdog expired: keep earlier results and skip the remaining pairs
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WD_WIDTH'(1);
                end
            end
            S_WRITE: begin
                if (idx_q == last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + BRAM_WIDTH'(1);
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes and addresses come from the state, and are zero outside their states
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.job_done  = (state_q == S_DONE);
        bus.job_error = error_q;
        bus.mem_rd_en = 1'b0;
        bus.mem_raddr = '0;
        bus.mem_wr_en = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.fpu_start = (state_q == S_ISSUE);
        bus.fpu_op    = op_q;
        bus.fpu_a     = a_q;
        bus.fpu_b     = b_q;

        case (state_q)
            S_RD_A: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_raddr = pair_addr;
            end
            S_RD_B: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_raddr = pair_addr + BRAM_WIDTH'(1);
            end
            S_WRITE: begin
                bus.mem_wr_en = 1'b1;
                bus.mem_waddr = res_base_q + idx_q;
                bus.mem_wdata = res_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_job_sequencer.sv
// Directed bench for fpu_job_sequencer. It provides a BRAM model with a 1-cycle read,
// and an adder FPU model with 31-cycle latency that can be told never to finish.
// A negedge monitor logs reads, writes, issues and job_done pulses.
module tb_fpu_job_sequencer;

    localparam int BW      = 10;
    localparam int DW      = 32;
    localparam int FPU_LAT = 31;

    logic clock;
    logic reset_n;

    fpu_job_sequencer_if #(.BRAM_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    fpu_job_sequencer #(.BRAM_WIDTH(BW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- BRAM model ----------------
    logic [DW-1:0] mem [0:(1<<BW)-1];
    logic          ld_en   = 1'b0;
    logic [BW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clock) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_raddr];
        if (bus.mem_wr_en) mem[bus.mem_waddr] <= bus.mem_wdata;
        else if (ld_en)    mem[ld_addr] <= ld_data;
    end

    // ---------------- FPU model (a+b after FPU_LAT cycles) ----------------
    bit            fpu_never = 1'b0;
    int            fcnt;
    logic [DW-1:0] fres;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt           <= 0;
            fres           <= '0;
            bus.fpu_done   <= 1'b0;
            bus.fpu_result <= '0;
        end else begin
            bus.fpu_done <= 1'b0;
            if (bus.fpu_start) begin
                if (!fpu_never) fcnt <= FPU_LAT - 1;
                fres <= bus.fpu_a + bus.fpu_b;
            end else if (fcnt == 1) begin
                fcnt           <= 0;
                bus.fpu_done   <= 1'b1;
                bus.fpu_result <= fres;
            end else if (fcnt > 1) begin
                fcnt <= fcnt - 1;
            end
        end
    end

    // ---------------- Monitor ----------------
    int            cyc = 0;
    logic [BW-1:0] rd_addr [$];
    int            rd_cyc  [$];
    logic [BW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    int            start_cnt = 0, done_cnt = 0, last_done_cyc = 0;
    int            unstable_cnt = 0, overlap_cnt = 0;
    bit            inflight = 1'b0;
    logic [DW-1:0] held_a, held_b;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            inflight = 1'b0;
        end else begin
            if (bus.mem_rd_en) begin
                rd_addr.push_back(bus.mem_raddr);
                rd_cyc.push_back(cyc);
            end
            if (bus.mem_wr_en) begin
                wr_addr.push_back(bus.mem_waddr);
                wr_data.push_back(bus.mem_wdata);
                $display("[%0d] write mem[0x%03h] = %0d", cyc, bus.mem_waddr, bus.mem_wdata);
            end
            if (bus.mem_rd_en && bus.mem_wr_en) overlap_cnt++;
            if (bus.fpu_start) begin
                start_cnt++;
                held_a   = bus.fpu_a;
                held_b   = bus.fpu_b;
                inflight = 1'b1;
            end else if (inflight) begin
                if (bus.fpu_a !== held_a || bus.fpu_b !== held_b) unstable_cnt++;
                if (bus.fpu_done) inflight = 1'b0;
            end
            if (bus.job_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic preload(input logic [BW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clock);
        ld_addr = addr;
        ld_data = data;
        ld_en   = 1'b1;
        @(negedge clock);
        ld_en   = 1'b0;
    endtask

    task automatic start_job(input logic [2:0] op, input logic [BW-1:0] base,
                             input logic [BW-1:0] rbase, input logic [BW-1:0] cnt);
        @(negedge clock);
        bus.job_op       = op;
        bus.job_base     = base;
        bus.job_res_base = rbase;
        bus.job_count    = cnt;
        bus.job_start    = 1'b1;
        @(negedge clock);
        bus.job_start    = 1'b0;
        $display("[%0d] job op=%0d base=0x%03h res_base=0x%03h count=%0d", cyc, op, base, rbase, cnt);
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        reset_n          = 1'b0;
        bus.job_start    = 1'b0;
        bus.job_op       = '0;
        bus.job_base     = '0;
        bus.job_res_base = '0;
        bus.job_count    = '0;
        repeat (3) @(negedge clock);
        n_chk++; if ({bus.busy, bus.job_done, bus.job_error} !== 3'b000)
            $display("FAIL reset_status: got %b want 000", {bus.busy, bus.job_done, bus.job_error}); else n_pass++;
        n_chk++; if ({bus.mem_rd_en, bus.mem_wr_en, bus.fpu_start} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {bus.mem_rd_en, bus.mem_wr_en, bus.fpu_start}); else n_pass++;
        n_chk++; if ({bus.fpu_op, bus.fpu_a, bus.fpu_b} !== '0)
            $display("FAIL reset_fpu_regs: got op=%0d a=%0h b=%0h want 0", bus.fpu_op, bus.fpu_a, bus.fpu_b); else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_after: busy=%b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_single_pair();
        int r0, w0, s0, d0;
        bit ok;
        preload(10'h010, 32'd3);
        preload(10'h011, 32'd5);
        r0 = rd_addr.size(); w0 = wr_addr.size(); s0 = start_cnt; d0 = done_cnt;
        start_job(3'd1, 10'h010, 10'h100, 10'd1);
        wait_done(d0, 200, ok);
        @(negedge clock);
        @(negedge clock);
        n_chk++; if (ok !== 1'b1) $display("FAIL t1_done_seen: got %b want 1", ok); else n_pass++;
        n_chk++; if (rd_addr.size() - r0 !== 2) $display("FAIL t1_reads: got %0d want 2", rd_addr.size() - r0); else n_pass++;
        if (rd_addr.size() - r0 >= 2) begin
            n_chk++; if (rd_addr[r0] !== 10'h010 || rd_addr[r0+1] !== 10'h011)
                $display("FAIL t1_raddr: got %h,%h want 010,011", rd_addr[r0], rd_addr[r0+1]); else n_pass++;
            n_chk++; if (last_done_cyc - rd_cyc[r0] !== 36)
                $display("FAIL t1_latency: got %0d want 36", last_done_cyc - rd_cyc[r0]); else n_pass++;
        end
        n_chk++; if (mem[10'h100] !== 32'd8) $display("FAIL t1_result: got %0d want 8", mem[10'h100]); else n_pass++;
        n_chk++; if (start_cnt - s0 !== 1) $display("FAIL t1_issues: got %0d want 1", start_cnt - s0); else n_pass++;
        n_chk++; if (wr_addr.size() - w0 !== 1) $display("FAIL t1_writes: got %0d want 1", wr_addr.size() - w0); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0 || bus.job_error !== 1'b0)
            $display("FAIL t1_end_state: busy=%b err=%b want 0 0", bus.busy, bus.job_error); else n_pass++;
    endtask

    task automatic test_multi_pair();
        int r0, w0, s0, d0;
        bit ok;
        logic [DW-1:0] ops [8];
        logic [DW-1:0] exp_res [4];
        ops = '{32'd1, 32'd2, 32'd10, 32'd20, 32'd100, 32'd200, 32'd7, 32'd9};
        exp_res = '{32'd3, 32'd30, 32'd300, 32'd16};
        for (int k = 0; k < 8; k++) preload(BW'(10'h020 + k), ops[k]);
        r0 = rd_addr.size(); w0 = wr_addr.size(); s0 = start_cnt; d0 = done_cnt;
        start_job(3'd2, 10'h020, 10'h200, 10'd4);
        wait_done(d0, 400, ok);
        @(negedge clock);
        n_chk++; if (ok !== 1'b1) $display("FAIL t2_done_seen: got %b want 1", ok); else n_pass++;
        n_chk++; if (wr_addr.size() - w0 !== 4) $display("FAIL t2_writes: got %0d want 4", wr_addr.size() - w0); else n_pass++;
        if (wr_addr.size() - w0 >= 4) begin
            for (int k = 0; k < 4; k++) begin
                n_chk++; if (wr_addr[w0+k] !== BW'(10'h200 + k) || wr_data[w0+k] !== exp_res[k])
                    $display("FAIL t2_write%0d: got 0x%03h=%0d want 0x%03h=%0d", k, wr_addr[w0+k], wr_data[w0+k],
                             BW'(10'h200 + k), exp_res[k]); else n_pass++;
            end
        end
        n_chk++; if (start_cnt - s0 !== 4) $display("FAIL t2_issues: got %0d want 4", start_cnt - s0); else n_pass++;
        if (rd_addr.size() > r0) begin
            n_chk++; if (last_done_cyc - rd_cyc[r0] !== 144)
                $display("FAIL t2_latency: got %0d want 144", last_done_cyc - rd_cyc[r0]); else n_pass++;
        end
        n_chk++; if (unstable_cnt !== 0) $display("FAIL t2_operand_stable: got %0d changes want 0", unstable_cnt); else n_pass++;
    endtask

    task automatic test_empty_jobs();
        int r0, w0, s0;
        r0 = rd_addr.size(); w0 = wr_addr.size(); s0 = start_cnt;
        // Illegal op: immediate DONE with error
        start_job(3'd0, 10'h000, 10'h000, 10'd3);
        n_chk++; if (bus.job_done !== 1'b1 || bus.job_error !== 1'b1)
            $display("FAIL t3_badop_done: done=%b err=%b want 1 1", bus.job_done, bus.job_error); else n_pass++;
        @(negedge clock);
        n_chk++; if (bus.job_done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL t3_badop_idle: done=%b busy=%b want 0 0", bus.job_done, bus.busy); else n_pass++;
        // Zero count: immediate DONE, error from the previous job cleared
        start_job(3'd1, 10'h000, 10'h000, 10'd0);
        n_chk++; if (bus.job_done !== 1'b1 || bus.job_error !== 1'b0)
            $display("FAIL t3_zero_done: done=%b err=%b want 1 0", bus.job_done, bus.job_error); else n_pass++;
        @(negedge clock);
        n_chk++; if (bus.job_done !== 1'b0) $display("FAIL t3_zero_pulse: done=%b want 0", bus.job_done); else n_pass++;
        n_chk++; if (rd_addr.size() != r0 || wr_addr.size() != w0 || start_cnt != s0)
            $display("FAIL t3_no_activity: reads=%0d writes=%0d issues=%0d want 0 0 0",
                     rd_addr.size() - r0, wr_addr.size() - w0, start_cnt - s0); else n_pass++;
    endtask

    task automatic test_timeout();
        int r0, w0, s0, d0;
        bit ok;
        preload(10'h030, 32'd1);
        preload(10'h031, 32'd2);
        preload(10'h140, 32'hDEAD);
        fpu_never = 1'b1;
        r0 = rd_addr.size(); w0 = wr_addr.size(); s0 = start_cnt; d0 = done_cnt;
        start_job(3'd3, 10'h030, 10'h140, 10'd2);
        wait_done(d0, 300, ok);
        @(negedge clock);
        fpu_never = 1'b0;
        n_chk++; if (ok !== 1'b1) $display("FAIL t4_done_seen: got %b want 1", ok); else n_pass++;
        n_chk++; if (bus.job_error !== 1'b1) $display("FAIL t4_error: got %b want 1", bus.job_error); else n_pass++;
        if (rd_addr.size() > r0) begin
            n_chk++; if (last_done_cyc - rd_cyc[r0] !== 68)
                $display("FAIL t4_latency: got %0d want 68", last_done_cyc - rd_cyc[r0]); else n_pass++;
        end
        n_chk++; if (wr_addr.size() - w0 !== 0 || mem[10'h140] !== 32'hDEAD)
            $display("FAIL t4_no_write: writes=%0d mem=%h want 0 dead", wr_addr.size() - w0, mem[10'h140]); else n_pass++;
        n_chk++; if (rd_addr.size() - r0 !== 2 || start_cnt - s0 !== 1)
            $display("FAIL t4_skip_rest: reads=%0d issues=%0d want 2 1", rd_addr.size() - r0, start_cnt - s0); else n_pass++;
    endtask

    task automatic test_wrap_and_ignore();
        int r0, w0, s0, d0;
        bit ok;
        logic [BW-1:0] exp_rd [4];
        exp_rd = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        preload(10'h3FE, 32'd4);
        preload(10'h3FF, 32'd6);
        preload(10'h000, 32'd11);
        preload(10'h001, 32'd22);
        r0 = rd_addr.size(); w0 = wr_addr.size(); s0 = start_cnt; d0 = done_cnt;
        start_job(3'd5, 10'h3FE, 10'h300, 10'd2);
        repeat (10) @(negedge clock);
        // Second request mid-job with illegal op and zero count must have no effect
        bus.job_op = 3'd0; bus.job_count = '0; bus.job_start = 1'b1;
        @(negedge clock);
        bus.job_start = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL t5_still_busy: got %b want 1", bus.busy); else n_pass++;
        wait_done(d0, 300, ok);
        @(negedge clock);
        n_chk++; if (ok !== 1'b1 || done_cnt - d0 !== 1) $display("FAIL t5_done_once: got %0d want 1", done_cnt - d0); else n_pass++;
        n_chk++; if (rd_addr.size() - r0 !== 4) $display("FAIL t5_reads: got %0d want 4", rd_addr.size() - r0); else n_pass++;
        if (rd_addr.size() - r0 >= 4) begin
            for (int k = 0; k < 4; k++) begin
                n_chk++; if (rd_addr[r0+k] !== exp_rd[k])
                    $display("FAIL t5_raddr%0d: got 0x%03h want 0x%03h", k, rd_addr[r0+k], exp_rd[k]); else n_pass++;
            end
            n_chk++; if (last_done_cyc - rd_cyc[r0] !== 72)
                $display("FAIL t5_latency: got %0d want 72", last_done_cyc - rd_cyc[r0]); else n_pass++;
        end
        n_chk++; if (mem[10'h300] !== 32'd10 || mem[10'h301] !== 32'd33)
            $display("FAIL t5_results: got %0d,%0d want 10,33", mem[10'h300], mem[10'h301]); else n_pass++;
        n_chk++; if (bus.fpu_op !== 3'd5 || bus.job_error !== 1'b0 || start_cnt - s0 !== 2)
            $display("FAIL t5_job_regs: op=%0d err=%b issues=%0d want 5 0 2", bus.fpu_op, bus.job_error, start_cnt - s0); else n_pass++;
        n_chk++; if (wr_addr.size() - w0 !== 2) $display("FAIL t5_writes: got %0d want 2", wr_addr.size() - w0); else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        int r0, w0, s0, d0;
        bit ok;
        for (int k = 0; k < 6; k++) preload(BW'(10'h040 + k), DW'(k + 1));
        w0 = wr_addr.size(); s0 = start_cnt; d0 = done_cnt;
        start_job(3'd2, 10'h040, 10'h180, 10'd3);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (start_cnt - s0 >= 2) begin ok = 1'b1; break; end
        end
        n_chk++; if (ok !== 1'b1) $display("FAIL t6_reached_pair2: got %b want 1", ok); else n_pass++;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if ({bus.busy, bus.job_done, bus.job_error, bus.mem_rd_en, bus.mem_wr_en, bus.fpu_start} !== 6'b0)
            $display("FAIL t6_async_flags: got %b want 000000",
                     {bus.busy, bus.job_done, bus.job_error, bus.mem_rd_en, bus.mem_wr_en, bus.fpu_start}); else n_pass++;
        n_chk++; if ({bus.fpu_op, bus.fpu_a, bus.fpu_b, bus.mem_raddr, bus.mem_waddr, bus.mem_wdata} !== '0)
            $display("FAIL t6_async_data: op=%0d a=%0h b=%0h want 0", bus.fpu_op, bus.fpu_a, bus.fpu_b); else n_pass++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        n_chk++; if (done_cnt - d0 !== 0 || wr_addr.size() - w0 !== 1 || bus.busy !== 1'b0)
            $display("FAIL t6_abandoned: dones=%0d writes=%0d busy=%b want 0 1 0",
                     done_cnt - d0, wr_addr.size() - w0, bus.busy); else n_pass++;
        // A fresh job after the reset runs normally
        preload(10'h050, 32'd100);
        preload(10'h051, 32'd23);
        r0 = rd_addr.size(); w0 = wr_addr.size(); d0 = done_cnt;
        start_job(3'd1, 10'h050, 10'h190, 10'd1);
        wait_done(d0, 200, ok);
        @(negedge clock);
        @(negedge clock);
        n_chk++; if (ok !== 1'b1 || mem[10'h190] !== 32'd123)
            $display("FAIL t6_new_job: done=%b result=%0d want 1 123", ok, mem[10'h190]); else n_pass++;
        if (rd_addr.size() > r0) begin
            n_chk++; if (last_done_cyc - rd_cyc[r0] !== 36)
                $display("FAIL t6_new_latency: got %0d want 36", last_done_cyc - rd_cyc[r0]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_multi_pair();
        test_empty_jobs();
        test_timeout();
        test_wrap_and_ignore();
        test_reset_mid_job();
        n_chk++; if (overlap_cnt !== 0) $display("FAIL rd_wr_overlap: got %0d want 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
